mac_array_ctrl: RTL



---
 rtl/mac_ctrl_pkg.sv | 19 +
 rtl/mac_ctrl_if.sv | 30 +++
 rtl/mac_ctrl_delay.sv | 28 ++
 rtl/mac_array_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC array sequencing controller.
package mac_ctrl_pkg;

   localparam int KSIZE_MAX = 5;
   localparam int OP_W      = 2;
   localparam int KSIZE_W   = 5;

   typedef logic [OP_W-1:0]    op_t;
   typedef logic [KSIZE_W-1:0] ksize_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/mac_ctrl_if.sv
// Command, weight and ifmap handshakes between the preload/AXI-stream front end and the controller.
interface mac_ctrl_if #(
   parameter int MAC_NUM = 256,
   parameter int CNT_W   = 16
);
   import mac_ctrl_pkg::*;

   logic                         cmd_valid;
   logic                         cmd_ready;
   op_t                          cmd_op;
   ksize_t                       cmd_ksize;
   logic [CNT_W-1:0]             cmd_cols;
   logic [$clog2(MAC_NUM+1)-1:0] cmd_mac_cnt;
   logic                         cmd_err;
   logic                         w_valid;
   logic                         w_ack;
   logic                         if_valid;
   logic                         if_ready;

   modport master (
      output cmd_valid, cmd_op, cmd_ksize, cmd_cols, cmd_mac_cnt, w_valid, if_valid,
      input  cmd_ready, cmd_err, w_ack, if_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_ksize, cmd_cols, cmd_mac_cnt, w_valid, if_valid,
      output cmd_ready, cmd_err, w_ack, if_ready
   );

endinterface

// File: rtl/mac_ctrl_delay.sv
// Single-bit delay line tracking psums in flight through the MAC array pipeline.
module mac_ctrl_delay #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inject,
   output logic pulse,
   output logic empty
);

   logic [DEPTH-1:0] line_q;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the line is cleared on reset so no psum flag survives an aborted command.
      if (!rst_n) begin
         line_q <= '0;
      end else begin
         // NOTE: state updates use <= so each stage samples its neighbour's pre-edge value.
         line_q <= (line_q >> 1) | (DEPTH'(inject) << (DEPTH - 1));
      end
   end

   assign pulse = line_q[0];
   // Nothing queued behind the flag emitted this cycle: the line is clear after this edge.
   assign empty = ((line_q >> 1) == '0);

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequences one convolution command: weight load, ifmap streaming and psum-valid flagging.
module mac_array_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int MAC_NUM = 256,
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   mac_ctrl_if.slave          bus,
   output logic [MAC_NUM-1:0] enable,
   output op_t                operation,
   output ksize_t             kernel_size,
   output logic               load_weight,
   output logic               load_ifmaps,
   output logic               psum_valid,
   output logic               busy,
   output logic               done
);

   localparam int MC_W = $clog2(MAC_NUM + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cols_q, col_q;
   logic [MC_W-1:0]  mac_cnt_q;
   logic             cmd_err_q;
   logic             cmd_legal, accept, reject;
   logic             beat, last_beat, inject, line_empty;

   assign cmd_legal = (bus.cmd_ksize != '0) && (bus.cmd_ksize <= KSIZE_W'(KSIZE_MAX))
                   && (bus.cmd_cols >= CNT_W'(bus.cmd_ksize))
                   && (bus.cmd_mac_cnt != '0) && (bus.cmd_mac_cnt <= MC_W'(MAC_NUM));

   assign accept    = (state_q == IDLE) && bus.cmd_valid && cmd_legal;
   assign reject    = (state_q == IDLE) && bus.cmd_valid && !cmd_legal;
   assign beat      = (state_q == STREAM) && bus.if_valid;
   assign last_beat = beat && (col_q == cols_q - CNT_W'(1));
   // A beat completes a kernel window once ksize columns have been shifted in.
   assign inject    = beat && (col_q >= CNT_W'(kernel_size) - CNT_W'(1));

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d       = state_q;
      bus.cmd_ready = 1'b0;
      bus.w_ack     = 1'b0;
      bus.if_ready  = 1'b0;
      load_weight   = 1'b0;
      load_ifmaps   = 1'b0;
      done          = 1'b0;
      busy          = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (accept) state_d = LOAD_W;
         end
         LOAD_W: begin
            load_weight = bus.w_valid;
            bus.w_ack   = bus.w_valid;
            if (bus.w_valid) state_d = STREAM;
         end
         STREAM: begin
            bus.if_ready = 1'b1;
            load_ifmaps  = bus.if_valid;
            if (last_beat) state_d = DRAIN;
         end
         DRAIN: begin
            if (line_empty) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      enable = '0;
      if (state_q != IDLE) begin
         for (int i = 0; i < MAC_NUM; i++) begin
            enable[i] = (i < int'(mac_cnt_q));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_err_q   <= 1'b0;
         operation   <= '0;
         kernel_size <= '0;
         cols_q      <= '0;
         mac_cnt_q   <= '0;
         col_q       <= '0;
      end else begin
         state_q   <= state_d;
         cmd_err_q <= reject;
         if (accept) begin
            operation   <= bus.cmd_op;
            kernel_size <= bus.cmd_ksize;
            cols_q      <= bus.cmd_cols;
            mac_cnt_q   <= bus.cmd_mac_cnt;
            col_q       <= '0;
         end else if (beat) begin
            col_q <= col_q + CNT_W'(1);
         end
      end
   end

   assign bus.cmd_err = cmd_err_q;

   mac_ctrl_delay #(.DEPTH(ALU_LAT)) u_delay (
      .clk    (clk),
      .rst_n  (rst_n),
      .inject (inject),
      .pulse  (psum_valid),
      .empty  (line_empty)
   );

endmodule
